// File: rtl/spi_flash_ctl_if.sv
// Host-side request/response bundle for the SPI flash controller.
// The host drives requests; the controller returns data and status.
interface spi_flash_ctl_if #(
  parameter int unsigned NBYTES = 4
) ();
  logic                  read;
  logic                  write;
  logic [23:0]           addr;
  logic [8*NBYTES-1:0]   din;
  logic [8*NBYTES-1:0]   dout;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (output read, write, addr, din, input dout, busy, done, err);
  modport slave  (input read, write, addr, din, output dout, busy, done, err);
endinterface

// File: rtl/spi_flash_ctl.sv
// SPI mode-0 flash controller: READ (0x03) and WREN/PROG/RDSR-poll write sequence.
// One cs frame per command; every frame is preceded by a 2*CLK_DIV cs-high gap.
module spi_flash_ctl #(
  parameter int unsigned FLASH_ADDR_SZ = 11,
  parameter int unsigned NBYTES        = 4,
  parameter int unsigned CLK_DIV       = 2,
  parameter int unsigned POLL_MAX      = 1024
) (
  input  logic            clk,
  input  logic            reset,
  spi_flash_ctl_if.slave  bus,
  output logic            spi_clk,
  output logic            spi_cs,
  output logic            spi_mosi,
  input  logic            spi_miso
);
  localparam int unsigned DW        = 8 * NBYTES;
  localparam int unsigned PAD       = 32 - DW;
  localparam int unsigned XFER_BITS = 32 + DW;
  localparam int unsigned GAP_LEN   = 2 * CLK_DIV;
  localparam int unsigned DIVW      = $clog2(GAP_LEN + 1);
  localparam int unsigned PCW       = $clog2(POLL_MAX + 1);
  localparam logic [23:0] ADDR_MASK = 24'((64'd1 << FLASH_ADDR_SZ) - 64'd1);

  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WREN, ST_PROG, ST_POLL, ST_DONE} state_t;
  typedef enum logic [1:0] {PH_GAP, PH_LO, PH_HI} phase_t;

  state_t            state, state_nxt;
  phase_t            phase;
  logic [DIVW-1:0]   div_cnt;
  logic [6:0]        bit_cnt;
  logic [63:0]       tx_sr;
  logic [DW-1:0]     rx_sr;
  logic [23:0]       addr_q;
  logic [DW-1:0]     din_q;
  logic [DW-1:0]     dout_q;
  logic [PCW-1:0]    poll_cnt;
  logic              busy_q, done_q, err_q;

  logic              in_cmd, frame_end, poll_last, wip;
  logic              accept, cap_dout, poll_inc, set_err;
  logic [63:0]       frame_data;
  logic [6:0]        frame_bits;

  assign bus.dout = dout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

  assign in_cmd    = (state == ST_READ) || (state == ST_WREN) || (state == ST_PROG) || (state == ST_POLL);
  assign frame_end = (phase == PH_HI) && (div_cnt == DIVW'(CLK_DIV - 1)) && (bit_cnt == 7'd1);
  assign poll_last = (poll_cnt == PCW'(POLL_MAX - 1));
  assign wip       = rx_sr[0];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!busy_q && (bus.read ^ bus.write)) state_nxt = bus.read ? ST_READ : ST_WREN;
      ST_READ: if (frame_end) state_nxt = ST_DONE;
      ST_WREN: if (frame_end) state_nxt = ST_PROG;
      ST_PROG: if (frame_end) state_nxt = ST_POLL;
      ST_POLL: if (frame_end && (!wip || poll_last)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    accept   = 1'b0;
    cap_dout = 1'b0;
    poll_inc = 1'b0;
    set_err  = 1'b0;
    case (state)
      ST_IDLE: accept = (state_nxt != ST_IDLE);
      ST_READ: cap_dout = frame_end;
      ST_POLL: begin
        poll_inc = frame_end;
        set_err  = frame_end && wip && poll_last;
      end
      default: ;
    endcase
  end

  // Frame contents, left-aligned so the MSB leaves first
  always_comb begin
    frame_data = '0;
    frame_bits = '0;
    case (state)
      ST_READ: begin
        frame_data = 64'({8'h03, addr_q}) << 32;
        frame_bits = 7'(XFER_BITS);
      end
      ST_WREN: begin
        frame_data = 64'(8'h06) << 56;
        frame_bits = 7'd8;
      end
      ST_PROG: begin
        frame_data = 64'({8'h02, addr_q, din_q}) << PAD;
        frame_bits = 7'(XFER_BITS);
      end
      ST_POLL: begin
        frame_data = 64'(8'h05) << 56;
        frame_bits = 7'd16;
      end
      default: ;
    endcase
  end

  // Datapath, host outputs and SPI bit engine
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase    <= PH_GAP;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      poll_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      done_q <= (state_nxt == ST_DONE);
      busy_q <= (state_nxt == ST_READ) || (state_nxt == ST_WREN) ||
                (state_nxt == ST_PROG) || (state_nxt == ST_POLL);
      if (accept) begin
        addr_q   <= bus.addr & ADDR_MASK;
        din_q    <= bus.din;
        err_q    <= 1'b0;
        poll_cnt <= '0;
      end
      if (set_err) err_q <= 1'b1;
      if (cap_dout) dout_q <= rx_sr;
      if (poll_inc && (poll_cnt != PCW'(POLL_MAX))) poll_cnt <= poll_cnt + PCW'(1);

      if (!in_cmd) begin
        phase    <= PH_GAP;
        div_cnt  <= '0;
        bit_cnt  <= '0;
        spi_cs   <= 1'b1;
        spi_clk  <= 1'b0;
        spi_mosi <= 1'b0;
      end else begin
        case (phase)
          PH_GAP: begin
            if (div_cnt == DIVW'(GAP_LEN - 1)) begin
              div_cnt  <= '0;
              phase    <= PH_LO;
              spi_cs   <= 1'b0;
              spi_mosi <= frame_data[63];
              tx_sr    <= frame_data << 1;
              bit_cnt  <= frame_bits;
            end else begin
              div_cnt <= div_cnt + DIVW'(1);
            end
          end
          PH_LO: begin
            if (div_cnt == DIVW'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              phase   <= PH_HI;
              spi_clk <= 1'b1;
              rx_sr   <= {rx_sr[DW-2:0], spi_miso};
            end else begin
              div_cnt <= div_cnt + DIVW'(1);
            end
          end
          PH_HI: begin
            if (div_cnt == DIVW'(CLK_DIV - 1)) begin
              div_cnt <= '0;
              spi_clk <= 1'b0;
              if (bit_cnt == 7'd1) begin
                phase    <= PH_GAP;
                spi_cs   <= 1'b1;
                spi_mosi <= 1'b0;
              end else begin
                phase    <= PH_LO;
                spi_mosi <= tx_sr[63];
                tx_sr    <= tx_sr << 1;
                bit_cnt  <= bit_cnt - 7'd1;
              end
            end else begin
              div_cnt <= div_cnt + DIVW'(1);
            end
          end
          default: phase <= PH_GAP;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_ctl.sv
// Directed bench for spi_flash_ctl with a behavioural SPI flash that logs every
// cs frame (MOSI bytes, cs-low length) and answers READ and RDSR.
module tb_spi_flash_ctl;
  localparam int unsigned NB  = 4;
  localparam int unsigned CD  = 2;
  localparam int unsigned FAS = 11;
  localparam int unsigned PM  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_clk, spi_cs, spi_mosi;
  logic spi_miso = 1'b0;

  spi_flash_ctl_if #(.NBYTES(NB)) bus ();

  spi_flash_ctl #(.FLASH_ADDR_SZ(FAS), .NBYTES(NB), .CLK_DIV(CD), .POLL_MAX(PM)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- flash model ----------------
  logic [31:0] m_rdata = '0;
  int          m_wip = 0;
  int          rdsr_base = 0;
  int          rdsr_cnt = 0;
  logic [7:0]  fb [0:63][0:7];
  int          flen [0:63];
  int          fdur [0:63];
  int          nfr = 0;
  int          cur_bits = 0;
  logic [7:0]  cur_sh = '0;
  logic [7:0]  cur_cmd = '0;
  logic        prev_cs, prev_sclk;
  bit          in_frame = 0;
  bit          have_rise = 0;
  time         t_fall = 0;
  time         t_rise = 0;
  int          min_gap = 1000000;

  always @(spi_cs or spi_clk) begin
    if (spi_cs !== prev_cs) begin
      if (spi_cs === 1'b0) begin
        t_fall = $time;
        if (have_rise && int'(($time - t_rise) / 10) < min_gap) min_gap = int'(($time - t_rise) / 10);
        cur_bits = 0;
        cur_cmd  = '0;
        spi_miso = 1'b0;
        in_frame = 1;
      end else if (spi_cs === 1'b1 && in_frame) begin
        in_frame = 0;
        if (nfr < 64) begin
          flen[nfr] = cur_bits / 8;
          fdur[nfr] = int'(($time - t_fall) / 10);
        end
        nfr++;
        if (cur_cmd == 8'h05 && cur_bits == 16) rdsr_cnt++;
        t_rise = $time;
        have_rise = 1;
      end
      prev_cs = spi_cs;
    end
    if (spi_clk !== prev_sclk) begin
      if (spi_clk === 1'b1 && in_frame) begin
        cur_sh = {cur_sh[6:0], spi_mosi};
        cur_bits++;
        if (cur_bits % 8 == 0) begin
          if (nfr < 64 && cur_bits <= 64) fb[nfr][cur_bits/8-1] = cur_sh;
          if (cur_bits == 8) cur_cmd = cur_sh;
        end
      end else if (spi_clk === 1'b0 && in_frame) begin
        logic [7:0] st;
        st = ((rdsr_cnt - rdsr_base) < m_wip) ? 8'h03 : 8'h02;
        if (cur_cmd == 8'h03 && cur_bits >= 32 && cur_bits < 64) spi_miso = m_rdata[31-(cur_bits-32)];
        else if (cur_cmd == 8'h05 && cur_bits >= 8 && cur_bits < 16) spi_miso = st[7-(cur_bits-8)];
        else spi_miso = 1'b0;
      end
      prev_sclk = spi_clk;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input bit wr, input logic [23:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.read  = !wr;
    bus.write = wr;
    bus.addr  = a;
    bus.din   = d;
    @(negedge clk);
    bus.read  = 1'b0;
    bus.write = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_done(output int nd, output bit bb);
    int after;
    nd = 0;
    bb = 0;
    after = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        nd++;
        if (bus.busy !== 1'b0) bb = 1;
      end
      if (nd > 0) begin
        after++;
        if (after > 20) break;
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [31:0] din;
    int          wip;
    logic [31:0] rdata;
    logic [31:0] exp_dout;
    bit          exp_err;
    int          exp_frames;
    logic [23:0] exp_faddr;
  } vec_t;

  vec_t vecs [6];
  vec_t v;
  int   nd, base, mi;
  bit   bb, saw, ok;

  initial begin
    vecs[0] = '{wr:0, addr:24'h000123, din:32'h0,        wip:0,    rdata:32'hDEADBEEF, exp_dout:32'hDEADBEEF, exp_err:0, exp_frames:1,  exp_faddr:24'h000123};
    vecs[1] = '{wr:1, addr:24'h0007FF, din:32'hA5A50F0F, wip:3,    rdata:32'h0,        exp_dout:32'hDEADBEEF, exp_err:0, exp_frames:6,  exp_faddr:24'h0007FF};
    vecs[2] = '{wr:0, addr:24'h00F812, din:32'h0,        wip:0,    rdata:32'h12345678, exp_dout:32'h12345678, exp_err:0, exp_frames:1,  exp_faddr:24'h000012};
    vecs[3] = '{wr:1, addr:24'hABC555, din:32'h01020304, wip:1000, rdata:32'h0,        exp_dout:32'h12345678, exp_err:1, exp_frames:10, exp_faddr:24'h000555};
    vecs[4] = '{wr:0, addr:24'hFFFFFF, din:32'h0,        wip:0,    rdata:32'hCAFEF00D, exp_dout:32'hCAFEF00D, exp_err:0, exp_frames:1,  exp_faddr:24'h0007FF};
    vecs[5] = '{wr:1, addr:24'h000000, din:32'h80FF0001, wip:0,    rdata:32'h0,        exp_dout:32'hCAFEF00D, exp_err:0, exp_frames:3,  exp_faddr:24'h000000};

    bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_err",  64'(bus.err),  64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_cs",   64'(spi_cs),   64'd1);
    chk("rst_sclk", 64'(spi_clk),  64'd0);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);

    // read and write together is no operation
    reset = 1'b1;
    bus.read = 1'b1; bus.write = 1'b1; bus.addr = 24'h000010;
    saw = 0;
    repeat (30) begin
      @(negedge clk);
      if (spi_cs !== 1'b1 || bus.busy !== 1'b0) saw = 1;
    end
    bus.read = 1'b0; bus.write = 1'b0;
    chk("both_req_noop", 64'(saw), 64'd0);
    chk("both_req_frames", 64'(nfr), 64'd0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      m_rdata = v.rdata; m_wip = v.wip; rdsr_base = rdsr_cnt; base = nfr;
      issue(v.wr, v.addr, v.din);
      wait_done(nd, bb);
      mi = base + (v.wr ? 1 : 0);
      chk($sformatf("v%0d_done_count", i), 64'(nd), 64'd1);
      chk($sformatf("v%0d_busy_at_done", i), 64'(bb), 64'd0);
      chk($sformatf("v%0d_dout", i), 64'(bus.dout), 64'(v.exp_dout));
      chk($sformatf("v%0d_err", i), 64'(bus.err), 64'(v.exp_err));
      chk($sformatf("v%0d_frames", i), 64'(nfr - base), 64'(v.exp_frames));
      chk($sformatf("v%0d_cmd", i), 64'(fb[mi][0]), v.wr ? 64'h02 : 64'h03);
      chk($sformatf("v%0d_faddr", i), 64'({fb[mi][1], fb[mi][2], fb[mi][3]}), 64'(v.exp_faddr));
      chk($sformatf("v%0d_cs_low", i), 64'(fdur[mi]), 64'd256);
      if (v.wr) begin
        chk($sformatf("v%0d_wdata", i), 64'({fb[mi][4], fb[mi][5], fb[mi][6], fb[mi][7]}), 64'(v.din));
        chk($sformatf("v%0d_wren", i), 64'({fb[base][0], 8'(flen[base]), 8'(fdur[base])}), 64'h06_01_20);
        ok = 1;
        for (int k = base + 2; k < nfr && k < 64; k++)
          if (fb[k][0] !== 8'h05 || flen[k] != 2 || fdur[k] != 64) ok = 0;
        chk($sformatf("v%0d_rdsr_frames", i), 64'(ok), 64'd1);
      end
    end

    // second request while a read is busy is ignored
    m_rdata = 32'h0BADF00D; base = nfr;
    issue(0, 24'h000456, 32'h0);
    repeat (10) @(negedge clk);
    bus.write = 1'b1; bus.din = 32'h77777777;
    @(negedge clk);
    bus.write = 1'b0;
    repeat (40) @(negedge clk);
    bus.read = 1'b1; bus.addr = 24'h000111;
    @(negedge clk);
    bus.read = 1'b0;
    wait_done(nd, bb);
    chk("busy_req_done_count", 64'(nd), 64'd1);
    chk("busy_req_dout", 64'(bus.dout), 64'h0BADF00D);
    chk("busy_req_faddr", 64'({fb[base][1], fb[base][2], fb[base][3]}), 64'h000456);
    repeat (300) @(negedge clk);
    chk("busy_req_one_frame", 64'(nfr - base), 64'd1);

    // reset in the middle of PROG data bits
    m_wip = 0; rdsr_base = rdsr_cnt; base = nfr;
    issue(1, 24'h000100, 32'h11223344);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (nfr == base + 1 && in_frame && cur_bits >= 40) begin ok = 1; break; end
    end
    chk("reached_prog_data", 64'(ok), 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", 64'(spi_cs), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_dout", 64'(bus.dout), 64'd0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    m_rdata = 32'h5A5AC3C3; base = nfr;
    reset = 1'b1; bus.read = 1'b1; bus.addr = 24'h000321;
    @(negedge clk);
    bus.read = 1'b0;
    chk("accept_after_reset", 64'(bus.busy), 64'd1);
    wait_done(nd, bb);
    chk("post_reset_done", 64'(nd), 64'd1);
    chk("post_reset_dout", 64'(bus.dout), 64'h5A5AC3C3);
    chk("post_reset_faddr", 64'({fb[base][1], fb[base][2], fb[base][3]}), 64'h000321);
    chk("min_cs_gap_ok", 64'(min_gap >= 4), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
